hdmi_period_scheduler: RTL and testbench
========================================

// Module: hdmi_period_scheduler
// PURPOSE
//  Per-pixel period scheduler directly upstream of the three TMDS channel encoders. From the pixel
//  position counters it generates each channel's mode (0 ctrl, 1 video, 2 video guard, 3 island,
//  4 island guard) and control_data, including video/island preambles and guard bands.
//  It also sequences data-island packets with a request/start handshake to the packet assembler.
// PARAMETERS
//  FRAME_WIDTH    858  total pixels per line; cx runs 0..FRAME_WIDTH-1
//  SCREEN_WIDTH   720  active pixels per line; video when cx < SCREEN_WIDTH
//  FRAME_HEIGHT   525  total lines; cy runs 0..FRAME_HEIGHT-1
//  SCREEN_HEIGHT  480  active lines; video when cy < SCREEN_HEIGHT
//  DI_START_X     724  cx on which the island preamble begins (every line)
//  MAX_PACKETS    2    maximum packets per island, 1..18
//  DVI_OUTPUT     0    1 = no islands, preambles or guard bands (mode is only 0 or 1)
// PORTS
//  clk_pixel     in   1      pixel clock
//  reset         in   1      asynchronous, active-high
//  cx            in   BIT_W  horizontal position, BIT_W = $clog2(FRAME_WIDTH)
//  cy            in   BIT_H  vertical position, BIT_H = $clog2(FRAME_HEIGHT)
//  hsync, vsync  in   1      sync levels, already at output polarity
//  packet_req    in   1      assembler holds a packet ready for sending
//  mode          out  3      mode for all three channels
//  ctl_ch0       out  2      control_data, channel 0
//  ctl_ch1       out  2      control_data, channel 1
//  ctl_ch2       out  2      control_data, channel 2
//  packet_start  out  1      1-cycle pulse on the first pixel of each packet
//  packet_pixel  out  5      pixel index 0..31 within the current packet
// BEHAVIOUR
//  - Clock and reset: one clock, clk_pixel. Reset is asynchronous and active-high. While reset is
//    asserted: mode=0, ctl_ch0/1/2=0, packet_start=0, packet_pixel=0, FSM=IDLE, packet count=0.
//  - Latency: all outputs are registered. Outputs in cycle n+1 reflect cx/cy/hsync/vsync/packet_req
//    sampled in cycle n.
//  - ctl_ch0 = {vsync,hsync} at all times outside reset, including during guard bands, because the
//    encoder builds the channel-0 island guard from it.
//  - Default output is control: mode=0, ctl_ch1=ctl_ch2=00.
//  - Video: mode=1 when cx<SCREEN_WIDTH and cy<SCREEN_HEIGHT.
//  - nxt_active: (cy==FRAME_HEIGHT-1) ? 1 : (cy+1 < SCREEN_HEIGHT).
//  - Video preamble, when nxt_active and cx in [FRAME_WIDTH-10, FRAME_WIDTH-3]: mode=0, ctl_ch1=01,
//    ctl_ch2=00.
//  - Video guard band, when nxt_active and cx in [FRAME_WIDTH-2, FRAME_WIDTH-1]: mode=2.
//  - Island FSM states: IDLE, PRE (8 cycles), LGUARD (2), PACKET (32 per packet), TGUARD (2).
//    - IDLE->PRE on cx==DI_START_X && packet_req. Otherwise no island is sent on that line.
//    - PRE: mode=0, ctl_ch1=01, ctl_ch2=01.
//    - LGUARD and TGUARD: mode=4.
//    - PACKET: mode=3. packet_pixel counts 0..31. packet_start=1 when packet_pixel==0.
//    - At packet_pixel==31: stay in PACKET for another packet if packet_req && count<MAX_PACKETS,
//      otherwise go to TGUARD. count is the number of packets started in this island.
//    - TGUARD->IDLE. count resets to 0 on entry to PRE.
//    - packet_req is sampled only at DI_START_X and at packet_pixel==31. It may drop at any other time
//      without effect.
//  - Structural rule, checked by elaboration assertion:
//    DI_START_X >= SCREEN_WIDTH+4 and DI_START_X+12+32*MAX_PACKETS <= FRAME_WIDTH-10-4.
//    An island therefore never overlaps video, the video preamble, or the 4-pixel control minimum.
//  - Islands may occur on any line, blank or active. The FSM is advanced only by its own counters once
//    started; a cx jump mid-island does not abort the island.
//  - DVI_OUTPUT=1: FSM held in IDLE, ctl_ch1=ctl_ch2=00, mode is 1 or 0 only, packet_start never
//    pulses.
//  - Reset mid-island: outputs return to reset values immediately. After release, no island starts
//    before the next cx==DI_START_X.
// TESTING
//  - Default params, packet_req=0, full frame:
//    -> mode=1 for exactly 720x480 pixels.
//    -> mode=2 at cx 856,857 of lines 524 and 0..478 only.
//    -> never mode 3 or 4.
//  - packet_req=1 held, cx=724:
//    -> from the next cycle: 8 ctl cycles with ctl_ch1=ctl_ch2=01, 2 x mode 4, 64 x mode 3,
//       2 x mode 4.
//    -> packet_start pulses at island pixels 10 and 42.
//  - packet_req dropped during packet 1 (pixel 20):
//    -> one packet only; mode 4 at island offsets 42,43; mode 0 afterwards.
//  - hsync=1, vsync=0 during LGUARD:
//    -> ctl_ch0=01 while mode=4; with vsync toggled, ctl_ch0 follows one cycle later.
//  - reset asserted at packet_pixel=15:
//    -> mode=0, packet_pixel=0 asynchronously.
//    -> with packet_req=1 after release, the next island starts only at the next cx=724.
//  - DVI_OUTPUT=1, packet_req=1:
//    -> mode only 0/1, ctl_ch1/ctl_ch2 always 00, packet_start stays 0 over a full frame.

Source files
------------

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel period scheduler feeding the three TMDS encoders: video/control periods, preambles,
// guard bands and data-island sequencing with a packet request/start handshake.
module hdmi_period_scheduler #(
    parameter int FRAME_WIDTH   = 858,
    parameter int SCREEN_WIDTH  = 720,
    parameter int FRAME_HEIGHT  = 525,
    parameter int SCREEN_HEIGHT = 480,
    parameter int DI_START_X    = 724,
    parameter int MAX_PACKETS   = 2,
    parameter bit DVI_OUTPUT    = 1'b0,
    parameter int BIT_W         = $clog2(FRAME_WIDTH),
    parameter int BIT_H         = $clog2(FRAME_HEIGHT)
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic [BIT_W-1:0] cx,
    input  logic [BIT_H-1:0] cy,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             packet_req,
    output logic [2:0]       mode,
    output logic [1:0]       ctl_ch0,
    output logic [1:0]       ctl_ch1,
    output logic [1:0]       ctl_ch2,
    output logic             packet_start,
    output logic [4:0]       packet_pixel
);

    localparam int CNT_W = $clog2(MAX_PACKETS + 1);

    localparam logic [BIT_W-1:0] L_SCREEN_W = BIT_W'(SCREEN_WIDTH);
    localparam logic [BIT_W-1:0] L_DI_X     = BIT_W'(DI_START_X);
    localparam logic [BIT_W-1:0] L_PRE_LO   = BIT_W'(FRAME_WIDTH - 10);
    localparam logic [BIT_W-1:0] L_PRE_HI   = BIT_W'(FRAME_WIDTH - 3);
    localparam logic [BIT_W-1:0] L_GUARD_LO = BIT_W'(FRAME_WIDTH - 2);
    localparam logic [BIT_W-1:0] L_GUARD_HI = BIT_W'(FRAME_WIDTH - 1);
    localparam logic [BIT_H-1:0] L_SCREEN_H = BIT_H'(SCREEN_HEIGHT);
    localparam logic [BIT_H-1:0] L_LAST_Y   = BIT_H'(FRAME_HEIGHT - 1);
    localparam logic [BIT_H:0]   L_SCREEN_H_X = (BIT_H+1)'(SCREEN_HEIGHT);
    localparam logic [CNT_W-1:0] L_MAX_PKTS = CNT_W'(MAX_PACKETS);

    localparam logic [2:0] MODE_CTRL   = 3'd0;
    localparam logic [2:0] MODE_VIDEO  = 3'd1;
    localparam logic [2:0] MODE_VGUARD = 3'd2;
    localparam logic [2:0] MODE_ISLAND = 3'd3;
    localparam logic [2:0] MODE_IGUARD = 3'd4;

    generate
        if (DI_START_X < SCREEN_WIDTH + 4 ||
            DI_START_X + 12 + 32 * MAX_PACKETS > FRAME_WIDTH - 14 ||
            MAX_PACKETS < 1 || MAX_PACKETS > 18) begin : g_param_check
            $error("hdmi_period_scheduler: data island does not fit in horizontal blanking");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_LGUARD, S_PACKET, S_TGUARD} state_t;

    state_t           r_state, w_state_next;
    logic [4:0]       r_cnt, w_cnt_next;
    logic [CNT_W-1:0] r_pkts, w_pkts_next;
    logic [2:0]       r_mode, w_mode_next;
    logic [1:0]       r_ctl0, r_ctl1, r_ctl2, w_ctl1_next, w_ctl2_next;
    logic             r_start, w_start_next;
    logic [4:0]       r_pix, w_pix_next;

    logic [BIT_H:0] w_cy_inc;
    logic           w_nxt_active, w_video, w_vpre, w_vguard, w_island_go;

    assign w_cy_inc     = {1'b0, cy} + (BIT_H+1)'(1);
    assign w_nxt_active = (cy == L_LAST_Y) || (w_cy_inc < L_SCREEN_H_X);
    assign w_video      = (cx < L_SCREEN_W) && (cy < L_SCREEN_H);
    assign w_vpre       = !DVI_OUTPUT && w_nxt_active && (cx >= L_PRE_LO) && (cx <= L_PRE_HI);
    assign w_vguard     = !DVI_OUTPUT && w_nxt_active && (cx >= L_GUARD_LO) && (cx <= L_GUARD_HI);
    assign w_island_go  = !DVI_OUTPUT && (cx == L_DI_X) && packet_req;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pkts  <= '0;
            r_mode  <= MODE_CTRL;
            r_ctl0  <= 2'b00;
            r_ctl1  <= 2'b00;
            r_ctl2  <= 2'b00;
            r_start <= 1'b0;
            r_pix   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_pkts  <= w_pkts_next;
            r_mode  <= w_mode_next;
            r_ctl0  <= {vsync, hsync};
            r_ctl1  <= w_ctl1_next;
            r_ctl2  <= w_ctl2_next;
            r_start <= w_start_next;
            r_pix   <= w_pix_next;
        end
    end

    // Outputs are decoded from the next state so the first preamble pixel
    // appears on the cycle right after cx==DI_START_X is sampled.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 5'd1;
        w_pkts_next  = r_pkts;
        w_mode_next  = MODE_CTRL;
        w_ctl1_next  = 2'b00;
        w_ctl2_next  = 2'b00;
        w_start_next = 1'b0;
        w_pix_next   = '0;

        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (w_island_go) begin
                    w_state_next = S_PRE;
                    w_pkts_next  = '0;
                end
            end
            S_PRE: begin
                if (r_cnt == 5'd7) begin
                    w_state_next = S_LGUARD;
                    w_cnt_next   = '0;
                end
            end
            S_LGUARD: begin
                if (r_cnt == 5'd1) begin
                    w_state_next = S_PACKET;
                    w_cnt_next   = '0;
                    w_pkts_next  = r_pkts + CNT_W'(1);
                end
            end
            S_PACKET: begin
                if (r_cnt == 5'd31) begin
                    w_cnt_next = '0;
                    if (packet_req && (r_pkts < L_MAX_PKTS)) begin
                        w_pkts_next = r_pkts + CNT_W'(1);
                    end else begin
                        w_state_next = S_TGUARD;
                    end
                end
            end
            S_TGUARD: begin
                if (r_cnt == 5'd1) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase

        case (w_state_next)
            S_PRE: begin
                w_ctl1_next = 2'b01;
                w_ctl2_next = 2'b01;
            end
            S_LGUARD, S_TGUARD: w_mode_next = MODE_IGUARD;
            S_PACKET: begin
                w_mode_next  = MODE_ISLAND;
                w_pix_next   = w_cnt_next;
                w_start_next = (w_cnt_next == 5'd0);
            end
            default: begin
                if (w_vguard) begin
                    w_mode_next = MODE_VGUARD;
                end else if (w_vpre) begin
                    w_ctl1_next = 2'b01;
                end else if (w_video) begin
                    w_mode_next = MODE_VIDEO;
                end
            end
        endcase
    end

    assign mode         = r_mode;
    assign ctl_ch0      = r_ctl0;
    assign ctl_ch1      = r_ctl1;
    assign ctl_ch2      = r_ctl2;
    assign packet_start = r_start;
    assign packet_pixel = r_pix;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Randomized scoreboard bench for hdmi_period_scheduler: an HDMI instance and a DVI instance share
// stimulus; a line-level island model predicts every output cycle.
module tb_hdmi_period_scheduler;

    localparam int FW   = 858;
    localparam int SW   = 720;
    localparam int FH   = 525;
    localparam int SH   = 480;
    localparam int DIX  = 724;
    localparam int MAXP = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] cx, cy;
    logic       hsync, vsync, packet_req;

    logic [2:0] a_mode, b_mode;
    logic [1:0] a_c0, a_c1, a_c2, b_c0, b_c1, b_c2;
    logic       a_st, b_st;
    logic [4:0] a_pix, b_pix;

    always #5 clk = ~clk;

    hdmi_period_scheduler #(.DVI_OUTPUT(1'b0)) u_hdmi (
        .clk_pixel(clk), .reset(reset), .cx(cx), .cy(cy), .hsync(hsync), .vsync(vsync),
        .packet_req(packet_req), .mode(a_mode), .ctl_ch0(a_c0), .ctl_ch1(a_c1), .ctl_ch2(a_c2),
        .packet_start(a_st), .packet_pixel(a_pix)
    );

    hdmi_period_scheduler #(.DVI_OUTPUT(1'b1)) u_dvi (
        .clk_pixel(clk), .reset(reset), .cx(cx), .cy(cy), .hsync(hsync), .vsync(vsync),
        .packet_req(packet_req), .mode(b_mode), .ctl_ch0(b_c0), .ctl_ch1(b_c1), .ctl_ch2(b_c2),
        .packet_start(b_st), .packet_pixel(b_pix)
    );

    typedef struct {
        int          due;
        logic [14:0] hd;
        logic [14:0] dv;
        int          x;
        int          y;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // island model: k = island offset shown on the outputs (-1 none), np = packets committed
    int k  = -1;
    int np = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [14:0] pack(input int m, input logic [1:0] c0, input logic [1:0] c1,
                                         input logic [1:0] c2, input logic st, input int pix);
        return {3'(m), c0, c1, c2, st, 5'(pix)};
    endfunction

    function automatic logic [14:0] ref_ctrl(input int x, input int y, input logic [1:0] c0,
                                             input bit dvi);
        bit nxt;
        nxt = (y == FH - 1) || (y + 1 < SH);
        if (!dvi && nxt && x >= FW - 2 && x <= FW - 1) return pack(2, c0, 2'b00, 2'b00, 1'b0, 0);
        if (!dvi && nxt && x >= FW - 10 && x <= FW - 3) return pack(0, c0, 2'b01, 2'b00, 1'b0, 0);
        if (x < SW && y < SH) return pack(1, c0, 2'b00, 2'b00, 1'b0, 0);
        return pack(0, c0, 2'b00, 2'b00, 1'b0, 0);
    endfunction

    function automatic logic [14:0] ref_island(input int kk, input int n, input logic [1:0] c0);
        int p;
        if (kk < 8) return pack(0, c0, 2'b01, 2'b01, 1'b0, 0);
        if (kk < 10) return pack(4, c0, 2'b00, 2'b00, 1'b0, 0);
        if (kk < 10 + 32 * n) begin
            p = (kk - 10) % 32;
            return pack(3, c0, 2'b00, 2'b00, p == 0, p);
        end
        return pack(4, c0, 2'b00, 2'b00, 1'b0, 0);
    endfunction

    task automatic drive(input int x, input int y, input bit req);
        exp_t e;
        @(posedge clk);
        #2;
        cx         = 10'(x);
        cy         = 10'(y);
        hsync      = 1'($urandom);
        vsync      = 1'($urandom);
        packet_req = req;
        if (k >= 0) begin
            if (k == 10 + 32 * np - 1 && req && np < MAXP) np++;
            k++;
            if (k >= 12 + 32 * np) k = -1;
        end else if (x == DIX && req) begin
            k  = 0;
            np = 1;
        end
        e.hd  = (k >= 0) ? ref_island(k, np, {vsync, hsync}) : ref_ctrl(x, y, {vsync, hsync}, 1'b0);
        e.dv  = ref_ctrl(x, y, {vsync, hsync}, 1'b1);
        e.due = cyc + 1;
        e.x   = x;
        e.y   = y;
        exp_q.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        logic [14:0] ga, gb;
        ga = {a_mode, a_c0, a_c1, a_c2, a_st, a_pix};
        gb = {b_mode, b_c0, b_c1, b_c2, b_st, b_pix};
        checks += 2;
        if (ga !== 15'h0) begin
            errors++;
            $display("FAIL reset_%s hdmi got=%h expected=0000", tag, ga);
        end
        if (gb !== 15'h0) begin
            errors++;
            $display("FAIL reset_%s dvi got=%h expected=0000", tag, gb);
        end
        $display("reset check %s: hdmi=%h dvi=%h", tag, ga, gb);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        k  = -1;
        np = 0;
        #1;
        check_reset("mid_island");
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // monitor: outputs are valid every cycle; compare each expectation on its due cycle
    initial begin
        exp_t        e;
        logic [14:0] ga, gb;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e  = exp_q.pop_front();
                ga = {a_mode, a_c0, a_c1, a_c2, a_st, a_pix};
                gb = {b_mode, b_c0, b_c1, b_c2, b_st, b_pix};
                checks += 2;
                if (e.due != cyc) begin
                    errors += 2;
                    $display("FAIL stale_entry due=%0d now=%0d", e.due, cyc);
                end else begin
                    if (ga !== e.hd) begin
                        errors++;
                        $display("FAIL hdmi_out cx=%0d cy=%0d got=%h expected=%h (mode,c0,c1,c2,start,pix)",
                                 e.x, e.y, ga, e.hd);
                    end
                    if (gb !== e.dv) begin
                        errors++;
                        $display("FAIL dvi_out cx=%0d cy=%0d got=%h expected=%h (mode,c0,c1,c2,start,pix)",
                                 e.x, e.y, gb, e.dv);
                    end
                end
            end
        end
    end

    // line table: cy and packet_req policy
    // 0 req low, 1 req held, 2 random req, 3 req drops at packet pixel 20, 4 reset at packet pixel 15
    int ys[20]   = '{0, 1, 479, 480, 524, 523, 100, 478, 481, 300, 0, 200, 7, 350, 510, 479,
                     0, 0, 0, 0};
    int pols[20] = '{1, 2, 0, 1, 3, 4, 1, 2, 0, 3, 2, 4, 1, 2, 1, 0, 0, 0, 0, 0};

    initial begin
        reset      = 1'b1;
        cx         = '0;
        cy         = '0;
        hsync      = 1'b0;
        vsync      = 1'b0;
        packet_req = 1'b0;
        for (int i = 16; i < 20; i++) begin
            ys[i]   = int'($urandom_range(0, FH - 1));
            pols[i] = int'($urandom_range(0, 3));
        end
        #3;
        check_reset("power_on");
        @(posedge clk);
        #2;
        reset = 1'b0;

        for (int li = 0; li < 20; li++) begin
            int islands_before;
            islands_before = checks;
            for (int x = 0; x < FW; x++) begin
                bit req;
                case (pols[li])
                    0:       req = 1'b0;
                    1:       req = 1'b1;
                    2:       req = ($urandom_range(0, 3) != 0);
                    3:       req = (k < 30);
                    default: req = 1'b1;
                endcase
                if (pols[li] == 4 && k == 25) do_reset();
                drive(x, ys[li], req);
            end
            $display("line cy=%0d policy=%0d done, checks=%0d errors=%0d",
                     ys[li], pols[li], checks, errors);
        end

        repeat (3) @(posedge clk);
        #6;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
